// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out transmitter. A WIDTH-bit word is taken over a
//   valid/ready handshake and shifted out LSB first, one bit per clock, so a
//   downstream shift register that enters data at its MSB ends up holding the
//   word with bit 0 at q[0]. Optional GAP idle cycles follow every word.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   GAP        idle cycles after each word, sd_en=0 (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears all state
//   in_data    in   parallel word, sampled only on the transfer edge
//   in_valid   in   upstream has a word
//   in_ready   out  block can accept a word this cycle (combinational)
//   sd         out  serial data bit, registered
//   sd_en      out  sd carries a valid bit this cycle, registered
//   word_done  out  1-cycle pulse with the last bit (bit WIDTH-1), registered
//   busy       out  word in flight (SHIFT or GAP), registered
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 5,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sd,
  output logic             sd_en,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0]       r_gap_cnt;
  logic [3:0]       w_gap_cnt_nxt;
  logic             r_alive;
  logic             r_sd_en;
  logic             r_word_done;
  logic             r_busy;
  logic             w_last_bit;
  logic             w_xfer;

  // The bit currently on sd is presented in the last SHIFT cycle.
  assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

  // r_alive keeps in_ready low while reset is held and for the release cycle,
  // so a word offered during reset is never taken.
  assign in_ready = r_alive &&
                    ((r_state == S_IDLE) || (w_last_bit && (GAP == 0)));
  assign w_xfer   = in_valid && in_ready;

  // sd is the LSB of the shift register; zero-fill makes it 0 once a word
  // has drained, which is exactly the IDLE/GAP value.
  assign sd        = r_shreg[0];
  assign sd_en     = r_sd_en;
  assign word_done = r_word_done;
  assign busy      = r_busy;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_gap_cnt_nxt = r_gap_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = in_data;
          w_cnt_nxt   = '0;
        end
      end

      S_SHIFT: begin
        w_shreg_nxt = r_shreg >> 1;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (w_last_bit) begin
          if (w_xfer) begin
            // Back-to-back word: bit 0 follows the last bit with no bubble.
            w_shreg_nxt = in_data;
            w_cnt_nxt   = '0;
          end else if (GAP > 0) begin
            w_state_nxt   = S_GAP;
            w_cnt_nxt     = '0;
            w_gap_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = S_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_shreg_nxt   = '0;
        w_cnt_nxt     = '0;
        w_gap_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_alive   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_alive   <= 1'b1;
    end
  end

  // Status outputs are registered from the next-state view so they line up
  // with the bit that sd presents in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sd_en     <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sd_en     <= (w_state_nxt == S_SHIFT);
      r_word_done <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == LAST_BIT);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Two instances: d0 (WIDTH=5, GAP=0) and d1 (WIDTH=8, GAP=2), sharing clock
//   and reset. Drivers push words over the handshake; a per-instance monitor
//   keeps a reference model (transfer decision, expected bit queue, gap and
//   ready timing), pops one expected bit per presented cycle and compares all
//   outputs on the falling edge. A downstream SIPO model checks the captured
//   word at every word_done.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_v [2];
  logic [31:0] in_data_v  [2];

  logic sd0, en0, wd0, busy0, rdy0;
  logic sd1, en1, wd1, busy1, rdy1;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt [2] = '{0, 0};
  int q_len    [2] = '{0, 0};

  typedef struct packed {
    logic sd;
    logic en;
    logic wd;
    logic busy;
    logic rdy;
  } outs_t;

  typedef struct {
    logic        b;
    logic        last;
    logic [31:0] word;
  } entry_t;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(5), .GAP(0)) u_d0 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data_v[0][4:0]),
    .in_valid  (in_valid_v[0]),
    .in_ready  (rdy0),
    .sd        (sd0),
    .sd_en     (en0),
    .word_done (wd0),
    .busy      (busy0)
  );

  piso_serializer #(.WIDTH(8), .GAP(2)) u_d1 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data_v[1][7:0]),
    .in_valid  (in_valid_v[1]),
    .in_ready  (rdy1),
    .sd        (sd1),
    .sd_en     (en1),
    .word_done (wd1),
    .busy      (busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t get_out(input int id);
    if (id == 0) return '{sd0, en0, wd0, busy0, rdy0};
    else         return '{sd1, en1, wd1, busy1, rdy1};
  endfunction

  // Reference model + scoreboard for one instance of width w and gap g.
  task automatic monitor(input int id, input int w, input int g);
    entry_t      q[$];
    entry_t      e;
    outs_t       o;
    bit          alive = 1'b0;
    int          hold  = 0;
    int          gap   = 0;
    logic [31:0] sipo  = '0;
    logic [31:0] mask;
    logic        exp_en, exp_sd, exp_wd, exp_busy, exp_rdy;
    string       p;
    mask = 32'((64'd1 << w) - 1);
    p    = $sformatf("d%0d_", id);
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        q.delete();
        alive = 1'b0;
        hold  = 0;
        gap   = 0;
        sipo  = '0;
      end else begin
        if (alive && hold == 0 && in_valid_v[id] === 1'b1) begin
          for (int i = 0; i < w; i++)
            q.push_back('{b: in_data_v[id][i], last: (i == w - 1),
                          word: in_data_v[id] & mask});
          // Not-ready cycles until the next word can be accepted.
          hold = (g == 0) ? (w - 1) : (w + g);
          xfer_cnt[id]++;
        end else if (hold > 0) begin
          hold--;
        end
        alive = 1'b1;
      end

      @(negedge clk);
      o        = get_out(id);
      exp_rdy  = (reset === 1'b1) && alive && (hold == 0);
      exp_en   = 1'b0;
      exp_sd   = 1'b0;
      exp_wd   = 1'b0;
      exp_busy = 1'b0;
      if (q.size() > 0) begin
        e        = q.pop_front();
        exp_en   = 1'b1;
        exp_sd   = e.b;
        exp_wd   = e.last;
        exp_busy = 1'b1;
      end else if (gap > 0) begin
        exp_busy = 1'b1;
        gap--;
      end
      check({p, "sd_en"},     32'(o.en),   32'(exp_en));
      check({p, "sd"},        32'(o.sd),   32'(exp_sd));
      check({p, "word_done"}, 32'(o.wd),   32'(exp_wd));
      check({p, "busy"},      32'(o.busy), 32'(exp_busy));
      check({p, "in_ready"},  32'(o.rdy),  32'(exp_rdy));
      if (o.en === 1'b1)
        sipo = (sipo >> 1) | (32'(o.sd) << (w - 1));
      if (exp_en && e.last) begin
        check({p, "sipo_word"}, sipo & mask, e.word);
        gap = g;
      end
      q_len[id] = q.size();
    end
  endtask

  // Offer a word and hold in_valid until the model records the transfer.
  // in_valid is left high so a following send() runs back-to-back.
  task automatic send(input int id, input logic [31:0] data);
    int start;
    bit got;
    start          = xfer_cnt[id];
    got            = 1'b0;
    in_data_v[id]  = data;
    in_valid_v[id] = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = (xfer_cnt[id] != start);
    end
    if (!got) check($sformatf("d%0d_handshake_timeout", id), 32'(got), 32'd1);
    in_data_v[id] = $urandom;
  endtask

  task automatic rand_seq(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid_v[id] = 1'b0;
        in_data_v[id]  = $urandom;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      send(id, $urandom);
    end
    in_valid_v[id] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fork
      monitor(0, 5, 0);
      monitor(1, 8, 2);
    join_none

    // Reset held with words offered: nothing may be taken.
    reset         = 1'b0;
    in_valid_v[0] = 1'b1;
    in_valid_v[1] = 1'b1;
    in_data_v[0]  = 32'b10110;
    in_data_v[1]  = 32'hA5;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    fork
      begin
        send(0, 32'b10110);
        send(0, 32'h15);
        send(0, 32'h0A);
        in_valid_v[0] = 1'b0;
        repeat (8) @(negedge clk);
      end
      begin
        send(1, 32'hA5);
        in_valid_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        // One-cycle valid pulse mid-word must be ignored.
        in_valid_v[1] = 1'b1;
        in_data_v[1]  = $urandom;
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        send(1, $urandom);
        send(1, $urandom);
        in_valid_v[1] = 1'b0;
        repeat (14) @(negedge clk);
      end
    join

    // Reset in the middle of a word: outputs clear at once, no word_done.
    send(0, 32'h1F);
    in_valid_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("d0_rst_sd",        32'(sd0),   32'd0);
    check("d0_rst_sd_en",     32'(en0),   32'd0);
    check("d0_rst_busy",      32'(busy0), 32'd0);
    check("d0_rst_word_done", 32'(wd0),   32'd0);
    check("d0_rst_in_ready",  32'(rdy0),  32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    send(0, 32'h03);
    in_valid_v[0] = 1'b0;
    repeat (8) @(negedge clk);

    fork
      rand_seq(0, 40);
      rand_seq(1, 30);
    join
    repeat (40) @(negedge clk);
    check("d0_drained", 32'(q_len[0]), 32'd0);
    check("d1_drained", 32'(q_len[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
